// File: rtl/mux_nx1_mem_rr_pkg.sv
// Shared arbitration-mode encoding and channel-index wrap helper for the N:1 memory mux.
// Pure definitions only: no latency, no flow control.
package mux_mem_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Modulo-n increment written without '%' so non-power-of-two channel counts stay cheap.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_nx1_mem_rr_if.sv
// Producer-lane / consumer-lane bundle for mux_nx1_mem_rr; master drives inputs, slave is the mux.
// Wires only: no latency, no backpressure (valid-only qualification).
interface mux_nx1_mem_rr_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic                      mode;
   logic [SEL_W-1:0]          selector;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [CHANNELS-1:0]       valid_in;
   logic [WIDTH-1:0]          data_out;
   logic                      valid_out;
   logic [SEL_W-1:0]          sel_out;

   modport master (
      output mode, selector, data_in, valid_in,
      input  data_out, valid_out, sel_out
   );

   modport slave (
      input  mode, selector, data_in, valid_in,
      output data_out, valid_out, sel_out
   );
endinterface

// File: rtl/mux_nx1_mem_rr_arbiter.sv
// Rotating-priority search: first valid channel at or after rr_ptr, modulo CHANNELS.
// Purely combinational (0 cycles); no backpressure, grant_vld=0 when no channel is valid.
module rr_arbiter
   import mux_mem_pkg::*;
#(
   parameter int  CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] valid_in,
   input  logic [SEL_W-1:0]    rr_ptr,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                grant_vld
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = rr_ptr;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!grant_vld && valid_in[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
         idx = SEL_W'(wrap_inc(int'(idx), CHANNELS));
      end
   end

endmodule

// File: rtl/mux_nx1_mem_rr.sv
// N:1 valid-qualified mux with output memory; FIXED (external selector) or ROUND-ROBIN selection.
// Latency 1 cycle, all outputs registered; no backpressure, data_out/sel_out hold when nothing is granted.
module mux_nx1_mem_rr
   import mux_mem_pkg::*;
#(
   parameter int  WIDTH    = 4,
   parameter int  CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input logic              clk,
   input logic              reset,
   mux_nx1_mem_rr_if.slave  bus
);

   logic [WIDTH-1:0] ch_dat [CHANNELS];
   logic [SEL_W-1:0] rr_idx;
   logic             rr_vld;

   logic [WIDTH-1:0] data_q,   data_d;
   logic             vld_q,    vld_d;
   logic [SEL_W-1:0] sel_q,    sel_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
      assign ch_dat[k] = bus.data_in[k*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .valid_in  (bus.valid_in),
      .rr_ptr    (rr_ptr_q),
      .grant_idx (rr_idx),
      .grant_vld (rr_vld)
   );

   always_comb begin
      data_d   = data_q;
      vld_d    = 1'b0;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      if (bus.mode == MODE_RR) begin
         if (rr_vld) begin
            data_d   = ch_dat[rr_idx];
            vld_d    = 1'b1;
            sel_d    = rr_idx;
            rr_ptr_d = SEL_W'(wrap_inc(int'(rr_idx), CHANNELS));
         end
      end else if (int'(bus.selector) < CHANNELS) begin
         // Range test comes first so an out-of-range selector never indexes valid_in.
         if (bus.valid_in[bus.selector]) begin
            data_d = ch_dat[bus.selector];
            vld_d  = 1'b1;
            sel_d  = bus.selector;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '0;
         vld_q    <= 1'b0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         data_q   <= data_d;
         vld_q    <= vld_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.valid_out = vld_q;
   assign bus.sel_out   = sel_q;

endmodule

// File: tb/tb_mux_nx1_mem_rr.sv
// Bench for mux_nx1_mem_rr: 4-channel instance driven from a vector table, 3-channel instance by hand.
module tb_mux_nx1_mem_rr;
   import mux_mem_pkg::*;

   typedef struct {
      logic       rst;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] vin;
      logic [3:0] e_dat;
      logic       e_vld;
      logic [1:0] e_sel;
   } vec_t;

   typedef struct {
      int         inst;
      string      nm;
      logic [3:0] dat;
      logic       vld;
      logic [1:0] sel;
   } exp_t;

   logic clk = 1'b0;
   logic rst4;
   logic rst3;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   mux_nx1_mem_rr_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
   mux_nx1_mem_rr_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

   mux_nx1_mem_rr #(.WIDTH(4), .CHANNELS(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
   mux_nx1_mem_rr #(.WIDTH(4), .CHANNELS(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s, input logic [3:0] vi,
                               input logic [3:0] ed, input logic ev, input logic [1:0] es);
      vec_t v;
      v.rst = r; v.mode = m; v.sel = s; v.vin = vi;
      v.e_dat = ed; v.e_vld = ev; v.e_sel = es;
      return v;
   endfunction

   task automatic apply(input int inst, input vec_t v, input string nm);
      exp_t e;
      if (inst == 4) begin
         rst4 = v.rst; bus4.mode = v.mode; bus4.selector = v.sel; bus4.valid_in = v.vin;
      end else begin
         rst3 = v.rst; bus3.mode = v.mode; bus3.selector = v.sel; bus3.valid_in = v.vin[2:0];
      end
      e.inst = inst; e.nm = nm; e.dat = v.e_dat; e.vld = v.e_vld; e.sel = v.e_sel;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      if (e.inst == 4) begin
         check({e.nm, " data"},  bus4.data_out, e.dat);
         check({e.nm, " valid"}, {3'b000, bus4.valid_out}, {3'b000, e.vld});
         check({e.nm, " sel"},   {2'b00, bus4.sel_out}, {2'b00, e.sel});
      end else begin
         check({e.nm, " data"},  bus3.data_out, e.dat);
         check({e.nm, " valid"}, {3'b000, bus3.valid_out}, {3'b000, e.vld});
         check({e.nm, " sel"},   {2'b00, bus3.sel_out}, {2'b00, e.sel});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst4 = 1'b1; rst3 = 1'b1;
      bus4.mode = MODE_FIXED; bus4.selector = '0; bus4.valid_in = '0;
      bus3.mode = MODE_FIXED; bus3.selector = '0; bus3.valid_in = '0;
      bus4.data_in = {4'h1, 4'hC, 4'h2, 4'h0};
      bus3.data_in = {4'h7, 4'hA, 4'h5};

      //                 rst   mode        sel    vin      dat    vld   sel
      tbl.push_back(mk(1'b1, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b0, 2'd0)); // reset holds with valid
      tbl.push_back(mk(1'b1, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b0, 2'd0));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b1, 2'd0)); // fair rotation
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h2, 1'b1, 2'd1));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'hC, 1'b1, 2'd2));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h1, 1'b1, 2'd3));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b1, 2'd0)); // ptr now 1
      tbl.push_back(mk(1'b0, MODE_FIXED, 2'd2, 4'b0100, 4'hC, 1'b1, 2'd2));
      tbl.push_back(mk(1'b0, MODE_FIXED, 2'd2, 4'b0000, 4'hC, 1'b0, 2'd2)); // memory hold
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0100, 4'hC, 1'b1, 2'd2)); // ptr -> 3
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0011, 4'h0, 1'b1, 2'd0)); // skip 3, wrap
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0011, 4'h2, 1'b1, 2'd1));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0011, 4'h0, 1'b1, 2'd0));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0000, 4'h0, 1'b0, 2'd0)); // ptr stays 1
      tbl.push_back(mk(1'b0, MODE_FIXED, 2'd3, 4'b1000, 4'h1, 1'b1, 2'd3));
      tbl.push_back(mk(1'b0, MODE_FIXED, 2'd0, 4'b1110, 4'h1, 1'b0, 2'd3)); // invalid channel
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h2, 1'b1, 2'd1)); // ptr kept across modes
      tbl.push_back(mk(1'b1, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b0, 2'd0)); // reset mid-stream
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1111, 4'h0, 1'b1, 2'd0)); // search from ch0
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b1000, 4'h1, 1'b1, 2'd3));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0000, 4'h1, 1'b0, 2'd3));
      tbl.push_back(mk(1'b0, MODE_RR,    2'd0, 4'b0110, 4'h2, 1'b1, 2'd1)); // ptr wrapped to 0

      for (int i = 0; i < tbl.size(); i++) begin
         apply(4, tbl[i], $sformatf("c4_v%0d", i));
      end
      rst4 = 1'b1;

      // Three channels: out-of-range selector and modulo-3 pointer wrap.
      apply(3, mk(1'b1, MODE_RR,    2'd0, 4'b0111, 4'h0, 1'b0, 2'd0), "c3_reset");
      apply(3, mk(1'b0, MODE_FIXED, 2'd1, 4'b0111, 4'hA, 1'b1, 2'd1), "c3_fix1");
      apply(3, mk(1'b0, MODE_FIXED, 2'd3, 4'b0111, 4'hA, 1'b0, 2'd1), "c3_sel_oor");
      apply(3, mk(1'b0, MODE_FIXED, 2'd2, 4'b0011, 4'hA, 1'b0, 2'd1), "c3_fix_inv");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0111, 4'h5, 1'b1, 2'd0), "c3_rr0");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0111, 4'hA, 1'b1, 2'd1), "c3_rr1");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0111, 4'h7, 1'b1, 2'd2), "c3_rr2");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0111, 4'h5, 1'b1, 2'd0), "c3_rr_wrap");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0100, 4'h7, 1'b1, 2'd2), "c3_rr_skip");
      apply(3, mk(1'b0, MODE_RR,    2'd0, 4'b0010, 4'hA, 1'b1, 2'd1), "c3_rr_after_wrap");

      check("scoreboard_empty", 4'(sb_q.size()), 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
